// File: rtl/rca_pipe_pkg.sv
// Shared constants for the pipelined ripple-carry adder.
// Latency: n/a (constants only).
// Backpressure: n/a.

// Chunk width of one pipeline stage, guarded so repeated inclusion is harmless.
`ifndef RCA_PIPE_CW
`define RCA_PIPE_CW(w, s) ((w) / (s))
`endif

package rca_pipe_pkg;

    // Opcode encoding carried on the Sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rca_pipe_chunk.sv
// One-bit full adder cell and a CW-bit combinational ripple chain built from it.
// Latency: combinational, zero cycles.
// Backpressure: none; the enclosing stage register decides when results are captured.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_chunk
    import rca_pipe_pkg::*;
#(
    parameter int W = 9
) (
    output logic [W-1:0] S,
    output logic         Cout,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin
);
    // c[i] is the carry into bit i; c[W] leaves the chunk.
    logic [W:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fulladder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end

    assign Cout = c[W];
endmodule

// File: rtl/rca_pipe.sv
// Pipelined WIDTH-bit add/subtract split into STAGES ripple chunks, with signed overflow.
// Latency: STAGES cycles from acceptance to out_valid; one result per cycle.
// Backpressure: a stalled output freezes every stage; in_ready = ~out_valid | out_ready.

module rca_pipe
    import rca_pipe_pkg::*;
#(
    parameter int WIDTH  = 36,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = `RCA_PIPE_CW(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("rca_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    // Global advance: the whole pipe moves together, so a stalled output holds every stage.
    logic adv;

    // Operand B as actually added (inverted for subtract) and the stage-0 carry-in.
    logic [WIDTH-1:0] bx;
    logic             c0;

    // Per-stage state. r_q is a rotating word: each stage pushes its sum chunk in at the top
    // while the consumed A chunk drops off the bottom, so after the last stage it is exactly S.
    // b_q holds the not-yet-consumed chunks of B, lowest pending chunk at bit 0.
    logic [WIDTH-1:0] r_q [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    assign adv      = ~v_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    assign bx = (Sub == OP_SUB) ? ~B : B;
    assign c0 = (Sub == OP_ADD) ? Cin : 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] r_in;
        logic [WIDTH-1:0] b_in;
        logic             c_in;
        logic             v_in;
        logic [CW-1:0]    s_c;
        logic             co;

        if (k == 0) begin : g_first
            assign r_in = A;
            assign b_in = bx;
            assign c_in = c0;
            assign v_in = in_valid;
        end else begin : g_next
            assign r_in = r_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
        end

        rca_chunk #(.W(CW)) u_chunk (
            .S    (s_c),
            .Cout (co),
            .A    (r_in[CW-1:0]),
            .B    (b_in[CW-1:0]),
            .Cin  (c_in)
        );

        assign r_d[k] = (r_in >> CW) | (WIDTH'(s_c) << (WIDTH - CW));
        assign b_d[k] = b_in >> CW;
        assign c_d[k] = co;
        assign v_d[k] = v_in;

        // Carry into the MSB is recovered from the MSB operand and sum bits of the top chunk.
        if (k == STAGES - 1) begin : g_last
            assign ovf_d = (r_in[CW-1] ^ b_in[CW-1] ^ s_c[CW-1]) ^ co;
        end
    end

    // Stage registers: cleared on reset, loaded together whenever the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_q[k] <= r_d[k];
                b_q[k] <= b_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign S         = r_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign Ovf       = ovf_q;
    assign out_valid = v_q[STAGES-1];
endmodule

// File: tb/tb_rca_pipe.sv
// Directed-vector and stream bench for rca_pipe at 36/4, 8/1 and 36/36.
// Latency: checked against the configured stage count.
// Backpressure: out_ready is toggled during the stream section.

module tb_rca_pipe;
    localparam int W  = 36;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance 36/4
    logic [W-1:0] a, b, s;
    logic         cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

    rca_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .S(s), .Cout(cout), .Ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Single-stage instance 8/1
    logic [7:0] a1, b1, s1;
    logic       cin1, sub1, iv1, ir1, cout1, ovf1, ov1, or1;

    rca_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
        .in_valid(iv1), .in_ready(ir1), .S(s1), .Cout(cout1), .Ovf(ovf1),
        .out_valid(ov1), .out_ready(or1)
    );

    // One-bit-per-stage instance 36/36
    logic [W-1:0] a36, b36, s36;
    logic         cin36, sub36, iv36, ir36, cout36, ovf36, ov36, or36;

    rca_pipe #(.WIDTH(W), .STAGES(W)) dut36 (
        .clk(clk), .rst(rst), .A(a36), .B(b36), .Cin(cin36), .Sub(sub36),
        .in_valid(iv36), .in_ready(ir36), .S(s36), .Cout(cout36), .Ovf(ovf36),
        .out_valid(ov36), .out_ready(or36)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; overflow by the sign rule on the operands added.
    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        vec_t         v;
        logic [W-1:0] bxm;
        logic [W:0]   t;
        bxm = msub ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bxm} + (msub ? {{W{1'b0}}, 1'b1} : {{W{1'b0}}, mcin});
        v.a    = ma;
        v.b    = mb;
        v.cin  = mcin;
        v.sub  = msub;
        v.s    = t[W-1:0];
        v.cout = t[W];
        v.ovf  = (ma[W-1] == bxm[W-1]) && (t[W-1] != ma[W-1]);
        return v;
    endfunction

    // Send one operand set on the main instance and check latency and result.
    task automatic run_main(input vec_t v, input string tag);
        int   lat;
        logic got;
        @(posedge clk);
        #1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        check({tag, " latency"}, lat, ST);
        check({tag, " S"}, s, v.s);
        check({tag, " Cout"}, cout, v.cout);
        check({tag, " Ovf"}, ovf, v.ovf);
    endtask

    vec_t vt [10];

    // Stream state
    vec_t         exp_q [$];
    vec_t         sv [16];
    vec_t         e;
    int           sent, rcvd, cyc;
    logic         stall_prev;
    logic [W-1:0] s_prev;
    logic         cout_prev, ovf_prev;
    logic         seen;
    int           lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Hand-computed vectors: {A, B, Cin, Sub, S, Cout, Ovf}
        vt[0] = '{36'hFFFFFFFFF, 36'h000000001, 1'b0, 1'b0, 36'h000000000, 1'b1, 1'b0};
        vt[1] = '{36'h000000005, 36'h000000007, 1'b0, 1'b1, 36'hFFFFFFFFE, 1'b0, 1'b0};
        vt[2] = '{36'h000000007, 36'h000000005, 1'b0, 1'b1, 36'h000000002, 1'b1, 1'b0};
        vt[3] = '{36'h7FFFFFFFF, 36'h000000001, 1'b0, 1'b0, 36'h800000000, 1'b0, 1'b1};
        vt[4] = '{36'h800000000, 36'h000000001, 1'b0, 1'b1, 36'h7FFFFFFFF, 1'b1, 1'b1};
        vt[5] = '{36'h123456789, 36'h0FEDCBA98, 1'b1, 1'b0, 36'h222222222, 1'b0, 1'b0};
        vt[6] = '{36'h000000010, 36'h000000010, 1'b1, 1'b1, 36'h000000000, 1'b1, 1'b0};
        vt[7] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1, 1'b0, 36'hFFFFFFFFF, 1'b1, 1'b0};
        vt[8] = '{36'h000000000, 36'h000000001, 1'b0, 1'b1, 36'hFFFFFFFFF, 1'b0, 1'b0};
        vt[9] = '{36'h800000000, 36'h800000000, 1'b0, 1'b0, 36'h000000000, 1'b1, 1'b1};

        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        a36 = '0; b36 = '0; cin36 = 1'b0; sub36 = 1'b0; iv36 = 1'b0; or36 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        check("reset S", s, '0);
        check("reset Cout", cout, 1'b0);
        check("reset Ovf", ovf, 1'b0);
        check("reset in_ready", in_ready, 1'b1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_main(vt[i], $sformatf("vec%0d", i));
        end

        // Stream of 16 with out_ready pattern 1,0,0 repeating
        for (int i = 0; i < 16; i++) begin
            sv[i] = model({$urandom_range(15, 0), $urandom}, {$urandom_range(15, 0), $urandom},
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0;
        s_prev = '0; cout_prev = 1'b0; ovf_prev = 1'b0;
        @(posedge clk);
        while (rcvd < 16 && cyc < 400) begin
            #1;
            out_ready = (cyc % 3 == 0);
            if (sent < 16) begin
                a = sv[sent].a; b = sv[sent].b; cin = sv[sent].cin; sub = sv[sent].sub;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("stream in_ready", in_ready, !(out_valid && !out_ready));
            if (stall_prev) begin
                check("stall out_valid", out_valid, 1'b1);
                check("stall S", s, s_prev);
                check("stall Cout", cout, cout_prev);
                check("stall Ovf", ovf, ovf_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected result", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("stream%0d S", rcvd), s, e.s);
                    check($sformatf("stream%0d Cout", rcvd), cout, e.cout);
                    check($sformatf("stream%0d Ovf", rcvd), ovf, e.ovf);
                end
                rcvd++;
            end
            stall_prev = out_valid && !out_ready;
            s_prev = s; cout_prev = cout; ovf_prev = ovf;
            if (in_valid && in_ready) begin
                exp_q.push_back(sv[sent]);
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream count", rcvd, 16);

        // Reset with three transactions in flight (first one already presented)
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            a = 36'h0F0F0F0F0 + 36'(i); b = 36'h111111111; cin = 1'b1; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre-reset out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid-reset out_valid", out_valid, 1'b0);
        check("mid-reset S", s, '0);
        check("mid-reset Cout", cout, 1'b0);
        check("mid-reset Ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no stale after reset", seen, 1'b0);
        run_main(model(36'h0000000AB, 36'h000000055, 1'b0, 1'b0), "post-reset");

        // STAGES = 1, WIDTH = 8
        @(posedge clk);
        #1;
        a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b1; sub1 = 1'b0; iv1 = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (ov1) seen = 1'b1;
        end
        check("s1 latency", lat, 1);
        check("s1 S", s1, 8'h01);
        check("s1 Cout", cout1, 1'b1);
        check("s1 Ovf", ovf1, 1'b0);

        // STAGES = 36, WIDTH = 36
        @(posedge clk);
        #1;
        a36 = 36'hFFFFFFFFF; b36 = 36'h000000001; cin36 = 1'b1; sub36 = 1'b0; iv36 = 1'b1;
        @(posedge clk);
        #1;
        iv36 = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (ov36) seen = 1'b1;
        end
        check("s36 latency", lat, 36);
        check("s36 S", s36, 36'h000000001);
        check("s36 Cout", cout36, 1'b1);
        check("s36 Ovf", ovf36, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, pipelined successor to the fixed 36-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple-carry chunks, with a register between chunks; operand upper bits are skewed to match.
- Valid/ready handshake on both sides with full backpressure. Signed-overflow output.
- Sits between operand producers and accumulator/ALU datapaths that need timing closure at wide widths.

Parameters:
- WIDTH, 36, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in, used only in add mode
- Sub  input  1  0 = A+B+Cin; 1 = A-B (B inverted, carry-in forced to 1, Cin ignored)
- in_valid  input  1  A/B/Cin/Sub valid
- in_ready  output  1  block accepts the operands this cycle
- S  output  WIDTH  result
- Cout  output  1  carry out of bit WIDTH-1 (in sub mode: 1 = no borrow)
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  S/Cout/Ovf valid
- out_ready  input  1  consumer accepts the result

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset: all stage valid bits, S, Cout and Ovf go to 0; in_ready = 1 once rst deasserts. Reset mid-operation discards all in-flight data; nothing is emitted afterwards.
- Global pipeline enable: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - Accept when in_valid & in_ready.
  - When adv = 0, every stage holds its data and valid bit.
- Stage k (0..STAGES-1):
  - Adds chunk k, bits [k*CW +: CW], of A and of (Sub ? ~B : B).
  - Carry-in: stage 0 uses (Sub ? 1 : Cin); stage k>0 uses the registered carry from stage k-1.
  - Registers the partial sum chunk, the carry out, and the not-yet-consumed upper operand chunks.
  - Lower completed sum chunks ride along in the stage register.
- Latency: exactly STAGES cycles from acceptance to out_valid with out_ready held high. Throughput is 1 result/cycle.
- A bubble (in_valid = 0 while adv = 1) propagates as valid = 0; there are no gaps between back-to-back results.
- Final stage registers drive S, Cout and Ovf directly; the output has no combinational path from A/B.
- Ovf is computed in the last stage from the carry into bit WIDTH-1 and the carry out of it.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Results leave in acceptance order: no reordering, loss or duplication under any out_ready pattern.
- Outputs hold stable while out_valid = 1 and out_ready = 0.
- STAGES = 1: a single registered full-width ripple adder with latency 1.

Decomposition:
- Shared constants include file: opcode encodings ADD = 0 and SUB = 1, plus a `define guard for the CW computation.
- Sub-module rca_chunk: a combinational CW-bit ripple adder built from the existing fulladder cell via a generate loop, with ports (S, Cout, A, B, Cin). It is instantiated once per stage.
- Elaboration-time check that WIDTH % STAGES == 0.

Test Plan:
- Default params: A = 36'hFFFFFFFFF, B = 1, Cin = 0, Sub = 0, out_ready = 1 → out_valid exactly 4 cycles after acceptance; S = 0, Cout = 1, Ovf = 0.
- Sub = 1, A = 5, B = 7 → S = 36'hFFFFFFFFE, Cout = 0, Ovf = 0. Then A = 7, B = 5 → S = 2, Cout = 1.
- A = 36'h7FFFFFFFF, B = 1, add → S = 36'h800000000, Ovf = 1. Sub with A = 36'h800000000, B = 1 → S = 36'h7FFFFFFFF, Ovf = 1.
- 16 back-to-back random operands with out_ready toggling 1,0,0,1,... → results match a reference model in order; in_ready = 0 exactly when out_valid & ~out_ready; outputs stable while stalled.
- rst pulsed for 1 cycle with 3 transactions in flight → out_valid = 0 and S/Cout/Ovf = 0 immediately, no stale result afterwards; a new transaction completes normally with latency 4.
- STAGES = 1, WIDTH = 8: 8'hFF + 8'h01 + Cin = 1 → S = 8'h01, Cout = 1, latency 1 cycle. STAGES = 36: same latency check with 36 cycles.
